// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter and its baud generator.
// State encoding is fixed so the states can be read directly in waveforms and debug dumps.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        QUAL  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } uart_state_t;

    // 100 MHz system clock, 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // 8N1: start + 8 data + stop
    localparam int FRAME_BITS = 10;

    function automatic int frame_bits(input int data_bits);
        return data_bits + 2;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Holding clear keeps it parked at 0, so the first bit after release is full length.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_WIDTH    = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam logic [CNT_WIDTH-1:0] TERMINAL = CNT_WIDTH'(CLKS_PER_BIT - 1);

    logic [CNT_WIDTH-1:0] cnt;

    assign bit_tick = !clear && (cnt == TERMINAL);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO one word at a time and sends each word as an 8N1 frame, LSB first.
// The tx pin comes straight from a flop, so it never glitches.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_WIDTH    = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_busy,
    output logic                  fifo_pop,
    output logic                  tx,
    output logic                  tx_active,
    output logic                  tx_done
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    uart_state_t           state, state_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic                  tx_q, tx_nxt;
    logic                  bit_tick;
    logic                  baud_clr;
    logic                  fifo_ok;

    assign fifo_ok  = !fifo_empty && !fifo_busy;
    // Counter sits at 0 until the start bit begins, giving a full-length start bit.
    assign baud_clr = (state == IDLE) || (state == QUAL);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_baud (
        .clock    (clock),
        .reset    (reset),
        .clear    (baud_clr),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        idx_nxt   = idx;
        fifo_pop  = 1'b0;
        tx_nxt    = 1'b1;
        case (state)
            IDLE: begin
                if (enable && fifo_ok) state_nxt = QUAL;
            end
            // Second idle cycle: FIFO read data is settled and the pop is always accepted.
            QUAL: begin
                fifo_pop = fifo_ok;
                if (fifo_ok) begin
                    shreg_nxt = fifo_data_out;
                    state_nxt = START;
                end else begin
                    state_nxt = IDLE;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_nxt = DATA;
                    idx_nxt   = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (idx == LAST_IDX) state_nxt = STOP;
                    else                 idx_nxt   = idx + 1'b1;
                end
            end
            STOP: begin
                if (bit_tick) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Pin value is computed for the coming cycle so tx can be registered.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg_nxt[idx_nxt];
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            shreg <= '0;
            idx   <= '0;
            tx_q  <= 1'b1;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            idx   <= idx_nxt;
            tx_q  <= tx_nxt;
        end
    end

    assign tx        = tx_q;
    assign tx_active = (state == START) || (state == DATA) || (state == STOP);
    assign tx_done   = (state == STOP) && bit_tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: queue-based FIFO model feeds the DUT, a line receiver
// rebuilds each frame from the tx pin and compares it against the expected byte queue.
module tb_fifo_uart_tx;

    localparam int DW   = 8;
    localparam int CPB  = 4;
    localparam int CW   = 10;
    localparam int FLEN = (DW + 2) * CPB;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_busy = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data_out;
    logic          fifo_pop, tx, tx_active, tx_done;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int pop_count   = 0;
    int done_count  = 0;
    int loaded      = 0;

    logic [7:0] fifoq[$];
    logic [7:0] exp_q[$];
    int         done_times[$];

    fifo_uart_tx #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB),
        .CNT_WIDTH    (CW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .fifo_data_out (fifo_data_out),
        .fifo_empty    (fifo_empty),
        .fifo_busy     (fifo_busy),
        .fifo_pop      (fifo_pop),
        .tx            (tx),
        .tx_active     (tx_active),
        .tx_done       (tx_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic load_byte(input logic [7:0] v);
        fifoq.push_back(v);
        exp_q.push_back(v);
        loaded++;
    endtask

    task automatic wait_done(input int target, input int budget);
        int t;
        t = 0;
        while (done_count < target && t < budget) begin
            @(posedge clock);
            t++;
        end
        #1;
        chk("frames_completed", done_count, target);
    endtask

    task automatic wait_active(input int budget);
        int t;
        t = 0;
        @(negedge clock);
        while (tx_active !== 1'b1 && t < budget) begin
            @(negedge clock);
            t++;
        end
        chk("frame_started", tx_active, 1);
    endtask

    // FIFO model: front word is presented as read data, a pop seen this cycle removes it.
    initial begin : fifo_model
        bit pop_now;
        fifo_empty    = 1'b1;
        fifo_data_out = '0;
        forever begin
            @(negedge clock);
            pop_now = (fifo_pop === 1'b1);
            if (pop_now) pop_count++;
            @(posedge clock);
            #1;
            if (pop_now && fifoq.size() > 0) void'(fifoq.pop_front());
            fifo_empty    = (fifoq.size() == 0);
            fifo_data_out = fifo_empty ? DW'($urandom) : fifoq[0];
        end
    end

    // Line receiver: records every active cycle, checks the whole frame on tx_done.
    initial begin : monitor
        logic       line [FLEN+8];
        logic [7:0] b, rx;
        logic       expb;
        int         n, bad, bp;
        n = 0;
        forever begin
            @(negedge clock);
            if (reset !== 1'b1) begin
                n = 0;
            end else begin
                if (tx_active === 1'b1) begin
                    if (n < FLEN + 8) line[n] = tx;
                    n++;
                end else begin
                    chk("tx_idle_high", tx, 1);
                end
                if (tx_done === 1'b1) begin
                    done_count++;
                    done_times.push_back(cyc);
                    chk("frame_len", n, FLEN);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 1, 0);
                    end else begin
                        b   = exp_q.pop_front();
                        bad = 0;
                        for (int k = 0; k < FLEN && k < n; k++) begin
                            bp   = k / CPB;
                            expb = (bp == 0) ? 1'b0 : (bp == DW + 1) ? 1'b1 : b[bp-1];
                            if (line[k] !== expb) bad++;
                        end
                        for (int i = 0; i < DW; i++) rx[i] = line[(i + 1) * CPB + CPB / 2];
                        chk("frame_byte", rx, b);
                        chk("frame_shape_errors", bad, 0);
                    end
                    n = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int         p0, d0, t0, bad, tgt;
        logic [7:0] v;

        // Reset held with random control inputs
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            enable    = 1'($urandom);
            fifo_busy = 1'($urandom);
            @(negedge clock);
            chk("rst_tx", tx, 1);
            chk("rst_tx_active", tx_active, 0);
            chk("rst_tx_done", tx_done, 0);
            chk("rst_fifo_pop", fifo_pop, 0);
        end
        @(posedge clock);
        #3;
        enable    = 1'b1;
        fifo_busy = 1'b0;
        reset     = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (tx !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0 || fifo_pop !== 1'b0) bad++;
        end
        chk("idle_after_reset_bad_cycles", bad, 0);

        // Single byte
        p0 = pop_count;
        d0 = done_count;
        load_byte(8'hA5);
        wait_done(d0 + 1, 200);
        chk("single_pop_count", pop_count - p0, 1);

        // Busy rises while qualifying: attempt aborted, retried later
        step(2);
        enable = 1'b0;
        load_byte(8'($urandom));
        step(3);
        p0 = pop_count;
        d0 = done_count;
        enable = 1'b1;
        @(posedge clock);
        #1;
        fifo_busy = 1'b1;
        @(negedge clock);
        chk("busy_qual_pop", fifo_pop, 0);
        step(6);
        chk("busy_no_pop", pop_count - p0, 0);
        chk("busy_no_frame", tx_active, 0);
        fifo_busy = 1'b0;
        wait_done(d0 + 1, 200);
        chk("busy_retry_pop_count", pop_count - p0, 1);

        // Back-to-back frames
        step(2);
        p0 = pop_count;
        d0 = done_count;
        t0 = done_times.size();
        load_byte(8'h00);
        load_byte(8'hFF);
        wait_done(d0 + 2, 300);
        chk("b2b_pop_count", pop_count - p0, 2);
        if (done_times.size() >= t0 + 2)
            chk("b2b_done_spacing", done_times[t0+1] - done_times[t0], FLEN + 2);

        // Reset in the middle of data bit 3
        step(2);
        v = 8'($urandom) & 8'hF7;
        p0 = pop_count;
        d0 = done_count;
        load_byte(v);
        load_byte(8'($urandom));
        wait_active(200);
        repeat (CPB + 3 * CPB + 1) @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("reset_tx_async", tx, 1);
        chk("reset_tx_active", tx_active, 0);
        chk("reset_fifo_pop", fifo_pop, 0);
        void'(exp_q.pop_front());
        bad = 0;
        repeat (5) begin
            @(negedge clock);
            if (fifo_pop !== 1'b0) bad++;
        end
        chk("reset_no_pop_cycles", bad, 0);
        #1;
        reset = 1'b1;
        wait_done(d0 + 1, 300);
        chk("reset_pop_count", pop_count - p0, 2);

        // Enable gating
        step(2);
        enable = 1'b0;
        load_byte(8'($urandom));
        load_byte(8'($urandom));
        p0 = pop_count;
        d0 = done_count;
        step(200);
        chk("disabled_no_pop", pop_count - p0, 0);
        enable = 1'b1;
        wait_active(50);
        #1;
        enable = 1'b0;
        wait_done(d0 + 1, 200);
        step(50);
        chk("enable_drop_pop_count", pop_count - p0, 1);
        chk("enable_drop_fifo_left", fifoq.size(), 1);

        // Random stream with random busy collisions
        enable = 1'b1;
        d0  = done_count;
        tgt = d0 + exp_q.size() + 20;
        for (int i = 0; i < 20; i++) begin
            load_byte(8'($urandom));
            repeat ($urandom_range(0, 60)) begin
                fifo_busy = ($urandom_range(0, 3) == 0);
                step(1);
            end
        end
        fifo_busy = 1'b0;
        wait_done(tgt, 25 * (FLEN + 10));
        step(5);

        chk("pops_equal_loaded", pop_count, loaded);
        chk("expected_queue_drained", exp_q.size(), 0);
        chk("fifo_model_drained", fifoq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
